charge_controller: RTL and testbench

Central control FSM of the coin-operated charger. It accepts debounced coin, confirm, cancel and power pulses plus a 1 Hz tick. It keeps the paid amount and remaining charge time as two-digit BCD values and drives the money/time digits, blanking flag and 3-bit state code consumed by the downstream display scan stage. All outputs are registered.

---
 rtl/charge_controller.sv | 170 +++++++++++++++++
 tb/tb_charge_controller.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/charge_controller.sv
// Central control FSM of the coin-operated charger.
// It tracks the paid amount and the remaining charge time as two-digit BCD values.
// It also drives the display digits, the blanking flag and the state code.
// Every output comes straight from a register.
module charge_controller #(
  parameter int unsigned MAX_MONEY     = 20,
  parameter int unsigned TIME_PER_COIN = 2,
  parameter int unsigned IDLE_TIMEOUT  = 10,
  parameter int unsigned DONE_HOLD     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       power_on,
  input  logic       power_off,
  input  logic       coin,
  input  logic       confirm,
  input  logic       cancel,
  output logic [3:0] money_1,
  output logic [3:0] money_2,
  output logic [3:0] time_1,
  output logic [3:0] time_2,
  output logic       no_display,
  output logic [2:0] current_state
);

  typedef enum logic [2:0] {
    StOff    = 3'd0,
    StIdle   = 3'd1,
    StInput  = 3'd2,
    StCharge = 3'd3,
    StDone   = 3'd4
  } state_e;

  localparam logic [6:0] MaxB    = 7'(MAX_MONEY);
  localparam logic [6:0] TpcB    = 7'(TIME_PER_COIN);
  localparam logic [7:0] TmoLim  = 8'(IDLE_TIMEOUT);
  localparam logic [7:0] HoldLim = 8'(DONE_HOLD);

  state_e     state_q, state_d;
  logic [7:0] money_q, money_d;  // {tens, ones} BCD
  logic [7:0] time_q, time_d;    // {tens, ones} BCD
  logic [7:0] tmo_q, tmo_d;      // ticks without a coin in INPUT
  logic [7:0] hold_q, hold_d;    // ticks spent in DONE
  logic       no_display_q, no_display_d;

  function automatic logic [6:0] from_bcd(input logic [7:0] d);
    return ({3'b000, d[7:4]} * 7'd10) + {3'b000, d[3:0]};
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] b);
    return {4'(b / 7'd10), 4'(b % 7'd10)};
  endfunction

  // Next-state and next-value logic; events are decoded in priority order.
  always_comb begin
    state_d      = state_q;
    money_d      = money_q;
    time_d       = time_q;
    tmo_d        = tmo_q;
    hold_d       = hold_q;
    if (power_off) begin
      state_d = StOff;
      money_d = 8'h00;
      time_d  = 8'h00;
      tmo_d   = 8'd0;
      hold_d  = 8'd0;
    end else begin
      case (state_q)
        StOff: begin
          if (power_on) state_d = StIdle;
        end
        StIdle: begin
          if (!cancel && !confirm && coin) begin
            state_d = StInput;
            money_d = to_bcd(7'd1);
            time_d  = to_bcd(TpcB);
            tmo_d   = 8'd0;
          end
        end
        StInput: begin
          if (cancel) begin
            state_d = StIdle;
            money_d = 8'h00;
            time_d  = 8'h00;
            tmo_d   = 8'd0;
          end else if (confirm) begin
            state_d = StCharge;
            tmo_d   = 8'd0;
          end else if (coin) begin
            // A coin beyond the ceiling is swallowed but still proves activity.
            if (from_bcd(money_q) < MaxB) begin
              money_d = to_bcd(from_bcd(money_q) + 7'd1);
              time_d  = to_bcd(from_bcd(time_q) + TpcB);
            end
            tmo_d = 8'd0;
          end else if (tick) begin
            if (tmo_q + 8'd1 >= TmoLim) begin
              state_d = StIdle;
              money_d = 8'h00;
              time_d  = 8'h00;
              tmo_d   = 8'd0;
            end else begin
              tmo_d = tmo_q + 8'd1;
            end
          end
        end
        StCharge: begin
          if (tick) begin
            if (from_bcd(time_q) <= 7'd1) begin
              state_d = StDone;
              time_d  = 8'h00;
              hold_d  = 8'd0;
            end else begin
              time_d = to_bcd(from_bcd(time_q) - 7'd1);
            end
          end
        end
        StDone: begin
          if (tick) begin
            if (hold_q + 8'd1 >= HoldLim) begin
              state_d = StIdle;
              money_d = 8'h00;
              time_d  = 8'h00;
              hold_d  = 8'd0;
            end else begin
              hold_d = hold_q + 8'd1;
            end
          end
        end
        default: begin
          // Unused codes fall back to a clean OFF.
          state_d = StOff;
          money_d = 8'h00;
          time_d  = 8'h00;
          tmo_d   = 8'd0;
          hold_d  = 8'd0;
        end
      endcase
    end
    no_display_d = (state_d == StOff);
  end

  // State and value registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StOff;
      money_q      <= 8'h00;
      time_q       <= 8'h00;
      tmo_q        <= 8'd0;
      hold_q       <= 8'd0;
      no_display_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      money_q      <= money_d;
      time_q       <= time_d;
      tmo_q        <= tmo_d;
      hold_q       <= hold_d;
      no_display_q <= no_display_d;
    end
  end

  assign money_1       = money_q[7:4];
  assign money_2       = money_q[3:0];
  assign time_1        = time_q[7:4];
  assign time_2        = time_q[3:0];
  assign no_display    = no_display_q;
  assign current_state = state_q;

endmodule

// File: tb/tb_charge_controller.sv
// Directed bench for charge_controller: a vector table for the main flow,
// plus hand-written sequences for saturation, timeout, priority and reset cases.
module tb_charge_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, power_on = 1'b0, power_off = 1'b0;
  logic       coin = 1'b0, confirm = 1'b0, cancel = 1'b0;
  logic [3:0] money_1, money_2, time_1, time_2;
  logic       no_display;
  logic [2:0] current_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Input encoding: [0]tick [1]power_on [2]power_off [3]coin [4]confirm [5]cancel [6]reset
  localparam logic [6:0] NOP = 7'h00, TCK = 7'h01, PON = 7'h02, POF = 7'h04;
  localparam logic [6:0] CON = 7'h08, CFM = 7'h10, CAN = 7'h20, RST = 7'h40;

  typedef struct {
    string      name;
    logic [6:0] in;
    logic [7:0] m;
    logic [7:0] t;
    logic       nd;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[$];

  charge_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .power_on     (power_on),
    .power_off    (power_off),
    .coin         (coin),
    .confirm      (confirm),
    .cancel       (cancel),
    .money_1      (money_1),
    .money_2      (money_2),
    .time_1       (time_1),
    .time_2       (time_2),
    .no_display   (no_display),
    .current_state(current_state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic [6:0] in, logic [7:0] m, logic [7:0] t,
                              logic nd, logic [2:0] st);
    vec_t v;
    v.name = name; v.in = in; v.m = m; v.t = t; v.nd = nd; v.st = st;
    return v;
  endfunction

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic drive(input logic [6:0] in);
    tick = in[0]; power_on = in[1]; power_off = in[2];
    coin = in[3]; confirm = in[4]; cancel = in[5]; rst_n = ~in[6];
    @(posedge clk);
    #1;
    tick = 1'b0; power_on = 1'b0; power_off = 1'b0;
    coin = 1'b0; confirm = 1'b0; cancel = 1'b0; rst_n = 1'b1;
  endtask

  task automatic chk(input string name, input logic [7:0] m, input logic [7:0] t,
                     input logic nd, input logic [2:0] st);
    logic [19:0] act, exp;
    act = {money_1, money_2, time_1, time_2, no_display, current_state};
    exp = {m, t, nd, st};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got money=%h time=%h nd=%b st=%0d, want money=%h time=%h nd=%b st=%0d",
               name, act[19:12], act[11:4], act[3], act[2:0], m, t, nd, st);
    end
  endtask

  task automatic step(input string name, input logic [6:0] in, input logic [7:0] m,
                      input logic [7:0] t, input logic nd, input logic [2:0] st);
    drive(in);
    chk(name, m, t, nd, st);
  endtask

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  initial begin
    int mon;

    // Main flow table: OFF -> IDLE -> INPUT -> CHARGE -> DONE -> IDLE.
    tbl.push_back(mk("reset",        RST, 8'h00, 8'h00, 1'b1, 3'd0));
    tbl.push_back(mk("off_coin_ign", CON, 8'h00, 8'h00, 1'b1, 3'd0));
    tbl.push_back(mk("power_on",     PON, 8'h00, 8'h00, 1'b0, 3'd1));
    tbl.push_back(mk("idle_tick",    TCK, 8'h00, 8'h00, 1'b0, 3'd1));
    tbl.push_back(mk("coin1",        CON, 8'h01, 8'h02, 1'b0, 3'd2));
    tbl.push_back(mk("coin2",        CON, 8'h02, 8'h04, 1'b0, 3'd2));
    tbl.push_back(mk("coin3",        CON, 8'h03, 8'h06, 1'b0, 3'd2));
    tbl.push_back(mk("confirm",      CFM, 8'h03, 8'h06, 1'b0, 3'd3));
    tbl.push_back(mk("chg_coin_ign", CON, 8'h03, 8'h06, 1'b0, 3'd3));
    tbl.push_back(mk("chg_can_ign",  CAN, 8'h03, 8'h06, 1'b0, 3'd3));
    tbl.push_back(mk("chg_t1",       TCK, 8'h03, 8'h05, 1'b0, 3'd3));
    tbl.push_back(mk("chg_t2",       TCK, 8'h03, 8'h04, 1'b0, 3'd3));
    tbl.push_back(mk("chg_t3",       TCK, 8'h03, 8'h03, 1'b0, 3'd3));
    tbl.push_back(mk("chg_t4",       TCK, 8'h03, 8'h02, 1'b0, 3'd3));
    tbl.push_back(mk("chg_t5",       TCK, 8'h03, 8'h01, 1'b0, 3'd3));
    tbl.push_back(mk("chg_t6_done",  TCK, 8'h03, 8'h00, 1'b0, 3'd4));
    tbl.push_back(mk("done_coin",    CON, 8'h03, 8'h00, 1'b0, 3'd4));
    tbl.push_back(mk("done_t1",      TCK, 8'h03, 8'h00, 1'b0, 3'd4));
    tbl.push_back(mk("done_t2",      TCK, 8'h03, 8'h00, 1'b0, 3'd4));
    tbl.push_back(mk("done_t3_idle", TCK, 8'h00, 8'h00, 1'b0, 3'd1));

    drive(RST);
    foreach (tbl[i]) step(tbl[i].name, tbl[i].in, tbl[i].m, tbl[i].t, tbl[i].nd, tbl[i].st);

    // Saturation: 25 coins; money caps at 20, time at 40.
    for (int i = 1; i <= 25; i++) begin
      mon = (i > 20) ? 20 : i;
      step($sformatf("sat_coin%0d", i), CON, bcd(mon), bcd(2 * mon), 1'b0, 3'd2);
    end
    step("sat_cancel", CAN, 8'h00, 8'h00, 1'b0, 3'd1);

    // Timeout: 10 coinless ticks return to IDLE.
    step("tmo_coin", CON, 8'h01, 8'h02, 1'b0, 3'd2);
    for (int i = 1; i <= 9; i++) step($sformatf("tmo_tick%0d", i), TCK, 8'h01, 8'h02, 1'b0, 3'd2);
    step("tmo_tick10", TCK, 8'h00, 8'h00, 1'b0, 3'd1);

    // Coin with tick 9 clears the counter; the tick itself is not counted.
    step("tmo2_coin", CON, 8'h01, 8'h02, 1'b0, 3'd2);
    for (int i = 1; i <= 8; i++) drive(TCK);
    step("tmo2_coin_tick9", CON | TCK, 8'h02, 8'h04, 1'b0, 3'd2);
    for (int i = 1; i <= 9; i++) drive(TCK);
    step("tmo2_after9", NOP, 8'h02, 8'h04, 1'b0, 3'd2);
    step("tmo2_tick10", TCK, 8'h00, 8'h00, 1'b0, 3'd1);

    // Priority: cancel beats confirm; power_off beats coin.
    for (int i = 1; i <= 5; i++) drive(CON);
    chk("pri_money5", 8'h05, 8'h10, 1'b0, 3'd2);
    step("pri_cancel_confirm", CAN | CFM, 8'h00, 8'h00, 1'b0, 3'd1);
    step("pri_poff_coin", POF | CON, 8'h00, 8'h00, 1'b1, 3'd0);

    // power_off mid-CHARGE clears everything.
    drive(PON); drive(CON); drive(CFM);
    step("poff_charge", POF, 8'h00, 8'h00, 1'b1, 3'd0);

    // BCD borrow 10 -> 09 and carry 09 -> 10, then reset mid-CHARGE at 07.
    drive(PON);
    for (int i = 1; i <= 9; i++) drive(CON);
    chk("bcd_m09", 8'h09, 8'h18, 1'b0, 3'd2);
    step("bcd_m10", CON, 8'h10, 8'h20, 1'b0, 3'd2);
    step("cancel10", CAN, 8'h00, 8'h00, 1'b0, 3'd1);
    for (int i = 1; i <= 5; i++) drive(CON);
    step("bcd_confirm", CFM, 8'h05, 8'h10, 1'b0, 3'd3);
    step("bcd_t09", TCK, 8'h05, 8'h09, 1'b0, 3'd3);
    drive(TCK);
    step("bcd_t07", TCK, 8'h05, 8'h07, 1'b0, 3'd3);
    step("reset_mid_charge", RST | TCK, 8'h00, 8'h00, 1'b1, 3'd0);
    step("after_reset_tick", TCK, 8'h00, 8'h00, 1'b1, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
